// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RV64 core: CSR read/write port,
// trap entry/return bookkeeping, and free-running cycle/instret counters.
module csr_file (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_csr_addr,
    input  logic [1:0]  i_csr_opt,
    input  logic [63:0] i_csrd,
    output logic [63:0] o_csrs,
    input  logic [63:0] i_pc,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic        i_retire,
    output logic [63:0] o_trap_pc,
    output logic [63:0] o_mret_pc,
    output logic        o_illegal
);

    localparam logic [1:0]  CSR_NOP = 2'd0;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

    // mstatus image: UXL/SXL are hard-wired to 2 (64-bit), only MIE/MPIE/MPP are real flops
    function automatic logic [63:0] pack_mstatus(input logic mie_f, input logic mpie_f,
                                                 input logic [1:0] mpp_f);
        pack_mstatus = {28'd0, 4'hA, 19'd0, mpp_f, 3'd0, mpie_f, 3'd0, mie_f, 3'd0};
    endfunction

    function automatic logic [63:0] align4(input logic [63:0] value);
        align4 = {value[63:2], 2'b00};
    endfunction

    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        addr_impl;
    logic        addr_ro;
    logic        wr_en;
    logic        wr_mstatus;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mcycle;
    logic        wr_minstret;
    logic        trap_event;

    // Address decode: implemented / read-only classification
    always_comb begin
        addr_impl = 1'b0;
        addr_ro   = 1'b0;
        case (i_csr_addr)
            ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MINSTRET: begin
                addr_impl = 1'b1;
                addr_ro   = 1'b0;
            end
            ADDR_MHARTID: begin
                addr_impl = 1'b1;
                addr_ro   = 1'b1;
            end
            default: begin
                addr_impl = 1'b0;
                addr_ro   = 1'b0;
            end
        endcase
    end

    // Per-register write enables; trap entry/return owns mstatus/mepc/mcause that cycle
    always_comb begin
        wr_en       = (i_csr_opt != CSR_NOP) && addr_impl && !addr_ro;
        trap_event  = i_ecall || i_mret;
        wr_mstatus  = 1'b0;
        wr_mtvec    = 1'b0;
        wr_mscratch = 1'b0;
        wr_mepc     = 1'b0;
        wr_mcause   = 1'b0;
        wr_mcycle   = 1'b0;
        wr_minstret = 1'b0;
        if (wr_en) begin
            case (i_csr_addr)
                ADDR_MSTATUS:  wr_mstatus  = !trap_event;
                ADDR_MTVEC:    wr_mtvec    = 1'b1;
                ADDR_MSCRATCH: wr_mscratch = 1'b1;
                ADDR_MEPC:     wr_mepc     = !trap_event;
                ADDR_MCAUSE:   wr_mcause   = !trap_event;
                ADDR_MCYCLE:   wr_mcycle   = 1'b1;
                ADDR_MINSTRET: wr_minstret = 1'b1;
                default:       wr_mtvec    = 1'b0;
            endcase
        end else begin
            wr_mtvec = 1'b0;
        end
    end

    // Zero-latency read mux from current register state
    always_comb begin
        o_csrs = 64'd0;
        case (i_csr_addr)
            ADDR_MSTATUS:  o_csrs = pack_mstatus(mie, mpie, mpp);
            ADDR_MTVEC:    o_csrs = mtvec;
            ADDR_MSCRATCH: o_csrs = mscratch;
            ADDR_MEPC:     o_csrs = mepc;
            ADDR_MCAUSE:   o_csrs = mcause;
            ADDR_MCYCLE:   o_csrs = mcycle;
            ADDR_MINSTRET: o_csrs = minstret;
            ADDR_MHARTID:  o_csrs = 64'd0;
            default:       o_csrs = 64'd0;
        endcase
    end

    // Illegal access: any operation on an unimplemented or read-only CSR
    always_comb begin
        o_illegal = 1'b0;
        if (i_csr_opt != CSR_NOP) begin
            o_illegal = !addr_impl || addr_ro;
        end else begin
            o_illegal = 1'b0;
        end
    end

    assign o_trap_pc = mtvec;
    assign o_mret_pc = mepc;

    // mstatus stored fields: ecall beats mret beats a CSR write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
            mpp  <= 2'b11;
        end else if (i_ecall) begin
            mpie <= mie;
            mie  <= 1'b0;
            mpp  <= 2'b11;
        end else if (i_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
            mpp  <= 2'b11;
        end else if (wr_mstatus) begin
            mie  <= i_csrd[3];
            mpie <= i_csrd[7];
            mpp  <= i_csrd[12:11];
        end else begin
            mie  <= mie;
            mpie <= mpie;
            mpp  <= mpp;
        end
    end

    // mepc / mcause: trap entry captures the faulting PC and cause
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mepc   <= 64'd0;
            mcause <= 64'd0;
        end else if (i_ecall) begin
            mepc   <= align4(i_pc);
            mcause <= CAUSE_ECALL_M;
        end else begin
            mepc   <= wr_mepc   ? align4(i_csrd) : mepc;
            mcause <= wr_mcause ? i_csrd         : mcause;
        end
    end

    // mtvec / mscratch: plain software-written registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtvec    <= 64'd0;
            mscratch <= 64'd0;
        end else begin
            mtvec    <= wr_mtvec    ? align4(i_csrd) : mtvec;
            mscratch <= wr_mscratch ? i_csrd         : mscratch;
        end
    end

    // Counters: a software write replaces that cycle's increment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else begin
            if (wr_mcycle) begin
                mcycle <= i_csrd;
            end else begin
                mcycle <= mcycle + 64'd1;
            end
            if (wr_minstret) begin
                minstret <= i_csrd;
            end else if (i_retire) begin
                minstret <= minstret + 64'd1;
            end else begin
                minstret <= minstret;
            end
        end
    end

endmodule
